spi_xfer_ctrl: RTL and testbench

Byte-stream transaction controller that sits directly upstream of the team's byte-level SPI master and feeds it. It buffers host bytes in a TX FIFO and launches one master transfer per byte. Each returned byte is collected into an RX FIFO. Host side uses valid/ready on both directions; master side uses the master's start/tx_data/busy/done/rx_data contract.

---
 rtl/spi_pkg.sv | 12 +
 rtl/sync_fifo.sv | 53 +++++
 rtl/spi_xfer_ctrl.sv | 133 +++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transfer controller slice.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DONE,
    GAP
  } xfer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is presented combinationally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [WIDTH-1:0]         o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;

  // A push into a full FIFO is accepted only when the head leaves the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Empty FIFO reads as zero so the head never exposes stale or unknown storage.
  assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone define validity and o_head masks empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// Feeds a byte-level SPI master from a TX FIFO and collects returned bytes in an RX FIFO.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    rx_discard,
  input  logic                    err_clr,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [SPI_BYTE_W-1:0]   wr_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [SPI_BYTE_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]  tx_level,
  output logic [$clog2(DEPTH):0]  rx_level,
  output logic                    active,
  output logic                    err_timeout,
  output logic                    spi_start,
  output logic [SPI_BYTE_W-1:0]   spi_tx_data,
  input  logic                    spi_busy,
  input  logic                    spi_done,
  input  logic [SPI_BYTE_W-1:0]   spi_rx_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  xfer_state_t           r_state;
  xfer_state_t           w_state_nxt;
  logic [TW-1:0]         r_tmo_cnt;
  logic                  r_spi_start;
  logic [SPI_BYTE_W-1:0] r_spi_tx_data;
  logic                  r_err_timeout;

  logic                  w_launch;
  logic                  w_rx_push;
  logic                  w_timeout;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic [SPI_BYTE_W-1:0] w_tx_head;

  assign wr_ready    = !w_tx_full;
  assign rd_valid    = !w_rx_empty;
  assign active      = (r_state != IDLE);
  assign err_timeout = r_err_timeout;
  assign spi_start   = r_spi_start;
  assign spi_tx_data = r_spi_tx_data;

  // Push is qualified by wr_ready so a full TX FIFO never takes a byte alongside a launch pop.
  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (wr_valid && wr_ready),
    .i_push_data (wr_data),
    .i_pop       (w_launch),
    .o_full      (w_tx_full),
    .o_empty     (w_tx_empty),
    .o_level     (tx_level),
    .o_head      (w_tx_head)
  );

  sync_fifo #(.WIDTH(SPI_BYTE_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_rx_push),
    .i_push_data (spi_rx_data),
    .i_pop       (rd_ready),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty),
    .o_level     (rx_level),
    .o_head      (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is defaulted first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_rx_push   = 1'b0;
    w_timeout   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable && !w_tx_empty && !spi_busy && (rx_discard || !w_rx_full)) begin
          w_launch    = 1'b1;
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (spi_done) begin
          w_rx_push   = !rx_discard;
          w_state_nxt = GAP;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = GAP;
        end
      end
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The launch edge zeroes the counter, so the timeout fires TIMEOUT_CYCLES edges after spi_start rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt     <= '0;
      r_spi_start   <= 1'b0;
      r_spi_tx_data <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_spi_start <= w_launch;
      if (w_launch) begin
        r_tmo_cnt     <= '0;
        r_spi_tx_data <= w_tx_head;
      end else if (r_state == WAIT_DONE) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
      if (w_timeout)    r_err_timeout <= 1'b1;
      else if (err_clr) r_err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl with a loopback SPI master model.
module tb_spi_xfer_ctrl;

  localparam int DEPTH    = 8;
  localparam int TMO      = 64;
  localparam int XFER_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       rx_discard = 1'b0;
  logic       err_clr = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       rd_ready = 1'b0;
  logic       wr_ready, rd_valid, active, err_timeout, spi_start;
  logic [7:0] rd_data, spi_tx_data;
  logic [3:0] tx_level, rx_level;
  logic       spi_busy, spi_done;
  logic [7:0] spi_rx_data;

  logic       m_hang = 1'b0;
  int         m_cnt;
  logic [7:0] m_byte;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int last_done = -100;

  spi_xfer_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .rx_discard  (rx_discard),
    .err_clr     (err_clr),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .tx_level    (tx_level),
    .rx_level    (rx_level),
    .active      (active),
    .err_timeout (err_timeout),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_busy    (spi_busy),
    .spi_done    (spi_done),
    .spi_rx_data (spi_rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Loopback master: busy for XFER_LEN cycles, then returns the byte it was sent.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_busy    <= 1'b0;
      spi_done    <= 1'b0;
      spi_rx_data <= 8'h00;
      m_cnt       <= 0;
      m_byte      <= 8'h00;
    end else begin
      spi_done <= 1'b0;
      if (spi_start && !m_hang) begin
        spi_busy <= 1'b1;
        m_cnt    <= XFER_LEN;
        m_byte   <= spi_tx_data;
      end else if (spi_busy) begin
        if (m_cnt > 1) begin
          m_cnt <= m_cnt - 1;
        end else begin
          spi_busy    <= 1'b0;
          spi_done    <= 1'b1;
          spi_rx_data <= m_byte;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (spi_start) begin
      start_cnt++;
      check("start_gap", 32'((cyc - last_done) >= 2), 1);
    end
    if (spi_done) last_done = cyc;
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    int t = 0;
    while (!wr_ready && t < 200) begin
      step();
      t++;
    end
    check("push_ready", 32'(wr_ready), 1);
    wr_valid = 1'b1;
    wr_data  = b;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int t = 0;
    while ((active || tx_level != 4'd0) && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(!active && tx_level == 4'd0), 1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int t = 0;
    while (!spi_start && t < budget) begin
      step();
      t++;
    end
    check(tag, 32'(spi_start), 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_ready"},    32'(wr_ready), 1);
    check({tag, "_rd_valid"},    32'(rd_valid), 0);
    check({tag, "_rd_data"},     32'(rd_data), 0);
    check({tag, "_tx_level"},    32'(tx_level), 0);
    check({tag, "_rx_level"},    32'(rx_level), 0);
    check({tag, "_active"},      32'(active), 0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 0);
    check({tag, "_spi_start"},   32'(spi_start), 0);
    check({tag, "_spi_tx_data"}, 32'(spi_tx_data), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int s1;
    int ts;

    // Reset state
    step(2);
    check_reset("rst");
    rst_n = 1'b1;
    step();

    // Single byte: one-cycle launch latency, loopback data lands in RX
    s0 = start_cnt;
    enable   = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'hA5;
    step();
    wr_valid = 1'b0;
    check("t1_no_start_yet", 32'(spi_start), 0);
    check("t1_tx_level", 32'(tx_level), 1);
    step();
    check("t1_start", 32'(spi_start), 1);
    check("t1_tx_data", 32'(spi_tx_data), 'hA5);
    check("t1_active", 32'(active), 1);
    check("t1_tx_popped", 32'(tx_level), 0);
    wait_idle("t1_idle", 100);
    step();
    check("t1_starts", 32'(start_cnt - s0), 1);
    check("t1_rx_level", 32'(rx_level), 1);
    check("t1_rd_valid", 32'(rd_valid), 1);
    check("t1_rd_data", 32'(rd_data), 'hA5);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("t1_rx_empty", 32'(rx_level), 0);

    // Burst of DEPTH bytes; 9th is refused while full
    enable = 1'b0;
    s0 = start_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("t2_tx_full", 32'(tx_level), 8);
    check("t2_wr_ready", 32'(wr_ready), 0);
    wr_valid = 1'b1;
    wr_data  = 8'h09;
    step();
    wr_valid = 1'b0;
    check("t2_drop", 32'(tx_level), 8);
    enable = 1'b1;
    wait_idle("t2_idle", 400);
    step();
    check("t2_starts", 32'(start_cnt - s0), 8);
    check("t2_rx_level", 32'(rx_level), 8);
    rd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check("t2_order", 32'(rd_data), 32'(i));
      step();
    end
    rd_ready = 1'b0;
    check("t2_rx_empty", 32'(rx_level), 0);

    // RX full stall, then relaunch after one pop
    s0 = start_cnt;
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    begin
      int t = 0;
      while (rx_level != 4'd8 && t < 400) begin
        step();
        t++;
      end
    end
    check("t3_rx_full", 32'(rx_level), 8);
    s1 = start_cnt;
    step(20);
    check("t3_stalled", 32'(start_cnt - s1), 0);
    check("t3_tx_left", 32'(tx_level), 2);
    check("t3_idle", 32'(active), 0);
    check("t3_head", 32'(rd_data), 'h10);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    wait_start("t3_relaunch", 2);
    rd_ready = 1'b1;
    wait_idle("t3_drain", 300);
    step(2);
    rd_ready = 1'b0;
    check("t3_starts", 32'(start_cnt - s0), 10);
    check("t3_rx_empty", 32'(rx_level), 0);

    // Discard mode
    rx_discard = 1'b1;
    s0 = start_cnt;
    push(8'h3C);
    push(8'hC3);
    wait_idle("t4_idle", 100);
    step();
    check("t4_starts", 32'(start_cnt - s0), 2);
    check("t4_rx_level", 32'(rx_level), 0);
    check("t4_rd_valid", 32'(rd_valid), 0);
    rx_discard = 1'b0;

    // Timeout: master never answers
    m_hang = 1'b1;
    push(8'h5A);
    wait_start("t5_start", 10);
    ts = cyc;
    begin
      int t = 0;
      while (!err_timeout && t < 200) begin
        step();
        t++;
      end
    end
    check("t5_err", 32'(err_timeout), 1);
    check("t5_latency", 32'(cyc - ts), TMO);
    check("t5_gap", 32'(active), 1);
    step();
    check("t5_back_idle", 32'(active), 0);
    check("t5_nothing_stored", 32'(rx_level), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t5_err_cleared", 32'(err_timeout), 0);
    m_hang = 1'b0;
    s0 = start_cnt;
    push(8'h77);
    wait_idle("t5_next_idle", 100);
    step();
    check("t5_next_starts", 32'(start_cnt - s0), 1);
    check("t5_next_data", 32'(rd_data), 'h77);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;

    // Reset mid-transfer with bytes still queued
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'hE0 + i));
    enable = 1'b1;
    wait_start("t6_start", 5);
    check("t6_tx_level", 32'(tx_level), 3);
    step();
    check("t6_in_flight", 32'(active), 1);
    #2 rst_n = 1'b0;
    #1 check_reset("t6_rst");
    step();
    rst_n = 1'b1;
    s0 = start_cnt;
    step(10);
    check("t6_no_start", 32'(start_cnt - s0), 0);
    check("t6_tx_level_post", 32'(tx_level), 0);
    check("t6_idle_post", 32'(active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
